note_player_poly: RTL and testbench

Polyphonic successor to the single-voice note player. It holds VOICES independent voices, each with its own phase accumulator, beat-based duration counter and waveform select. Voices are loaded one at a time through a shared load port, and their waveforms are mixed into one 16-bit signed sample per generate_next_sample request. It sits between the song/chord sequencer, which supplies the frequency-ROM step and duration, and the codec sample path.

---
 rtl/note_player_poly_if.sv | 72 +++++++
 rtl/note_player_poly.sv | 219 +++++++++++++++++++++
 tb/tb_note_player_poly.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_player_poly_if.sv
// -----------------------------------------------------------------------------
// note_player_poly_if
//   Bundles the sequencer-facing load/control signals and the codec-facing
//   sample outputs of note_player_poly.
//
//   master : sequencer / codec side (drives load, beat and request strobes)
//   slave  : the note player itself
//
//   Signals
//     play_enable          1 = play/count, 0 = pause
//     load_new_note        one-cycle load strobe
//     load_voice           target voice of the load
//     step_to_load         phase increment
//     duration_to_load     note length in beats
//     wave_to_load         00 square, 01 saw, 10 triangle, 11 silent
//     beat                 one-cycle beat tick
//     generate_next_sample one-cycle sample request
//     sample_out           signed mixed sample
//     new_sample_ready     one-cycle pulse, sample_out valid
//     done_with_note       per-voice one-cycle end-of-note pulse
//     voice_active         per-voice active flag
// -----------------------------------------------------------------------------
interface note_player_poly_if #(
    parameter int VIDX_W = 2,
    parameter int STEP_W = 20,
    parameter int DUR_W  = 6
);
    localparam int VOICES = 2 ** VIDX_W;

    logic                     play_enable;
    logic                     load_new_note;
    logic [VIDX_W-1:0]        load_voice;
    logic [STEP_W-1:0]        step_to_load;
    logic [DUR_W-1:0]         duration_to_load;
    logic [1:0]               wave_to_load;
    logic                     beat;
    logic                     generate_next_sample;
    logic signed [15:0]       sample_out;
    logic                     new_sample_ready;
    logic [VOICES-1:0]        done_with_note;
    logic [VOICES-1:0]        voice_active;

    modport master (
        output play_enable,
        output load_new_note,
        output load_voice,
        output step_to_load,
        output duration_to_load,
        output wave_to_load,
        output beat,
        output generate_next_sample,
        input  sample_out,
        input  new_sample_ready,
        input  done_with_note,
        input  voice_active
    );

    modport slave (
        input  play_enable,
        input  load_new_note,
        input  load_voice,
        input  step_to_load,
        input  duration_to_load,
        input  wave_to_load,
        input  beat,
        input  generate_next_sample,
        output sample_out,
        output new_sample_ready,
        output done_with_note,
        output voice_active
    );
endinterface

// File: rtl/note_player_poly.sv
// -----------------------------------------------------------------------------
// note_player_poly
//   Polyphonic note player. VOICES = 2**VIDX_W independent voices, each with a
//   phase accumulator, a beat-based duration counter and a waveform select.
//   Voices are loaded one at a time through the shared load port; on each
//   enabled sample request all voice waveforms are mixed into one signed
//   16-bit sample.
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous, active-low reset
//     bus    : note_player_poly_if.slave (load port, beat, sample request,
//              sample_out, new_sample_ready, done_with_note, voice_active)
//
//   Build option
//     NOTE_PLAYER_POLY_SAT_EN
//       undefined : each voice is shifted right by VIDX_W, then summed
//                   (cannot overflow).
//       defined   : full-scale voices are summed at 16+VIDX_W bits and
//                   saturated to [-32768, +32767].
//
//   Parameter constraints: PHASE_W >= 17, STEP_W <= PHASE_W. The interface
//   instance must use the same VIDX_W / STEP_W / DUR_W.
//
//   Per-voice state (no shared FSM):
//     active | meaning
//     0      | idle, contributes 0, duration not counted
//     1      | playing, phase advances on requests, duration counts beats
// -----------------------------------------------------------------------------
module note_player_poly #(
    parameter int VIDX_W  = 2,
    parameter int PHASE_W = 20,
    parameter int STEP_W  = 20,
    parameter int DUR_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    note_player_poly_if.slave    bus
);

    localparam int VOICES = 2 ** VIDX_W;
    localparam int ACC_W  = 16 + VIDX_W;

    localparam logic [1:0] WAVE_SQUARE   = 2'b00;
    localparam logic [1:0] WAVE_SAW      = 2'b01;
    localparam logic [1:0] WAVE_TRIANGLE = 2'b10;
    localparam logic [1:0] WAVE_SILENT   = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0]  phase_q [VOICES];
    logic [PHASE_W-1:0]  phase_d [VOICES];
    logic [STEP_W-1:0]   step_q  [VOICES];
    logic [STEP_W-1:0]   step_d  [VOICES];
    logic [DUR_W-1:0]    dur_q   [VOICES];
    logic [DUR_W-1:0]    dur_d   [VOICES];
    logic [1:0]          wave_q  [VOICES];
    logic [1:0]          wave_d  [VOICES];
    logic [VOICES-1:0]   active_q;
    logic [VOICES-1:0]   active_d;
    logic [VOICES-1:0]   done_q;
    logic [VOICES-1:0]   done_d;
    logic signed [15:0]  sample_q;
    logic signed [15:0]  sample_d;
    logic                ready_q;
    logic                ready_d;

    logic                beat_en;
    logic                gen_en;

    assign beat_en = bus.beat && bus.play_enable;
    assign gen_en  = bus.generate_next_sample && bus.play_enable;

    // -------------------------------------------------------------------------
    // Waveform of one voice from the top 16 phase bits.
    //   saw      : top16 - 32768            == top16 with MSB inverted
    //   triangle : rising  {a,0} - 32768    == {~a[14], a[13:0], 0}
    //              falling 32767 - {a,0}    == {a[14], ~a[13:0], 1}
    // -------------------------------------------------------------------------
    function automatic logic signed [15:0] voice_wave(
        input logic [15:0] top,
        input logic [1:0]  wave
    );
        logic [14:0]        a;
        logic signed [15:0] w;
        a = top[14:0];
        w = '0;
        case (wave)
            WAVE_SQUARE:   w = top[15] ? 16'sh8000 : 16'sh7FFF;
            WAVE_SAW:      w = {~top[15], top[14:0]};
            WAVE_TRIANGLE: w = top[15] ? {a[14], ~a[13:0], 1'b1}
                                       : {~a[14], a[13:0], 1'b0};
            WAVE_SILENT:   w = '0;
            default:       w = '0;
        endcase
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // Per-voice next state. A load to a voice overrides any beat or sample
    // activity on that voice in the same cycle, including a would-be done
    // pulse of the note it aborts.
    // -------------------------------------------------------------------------
    always_comb begin
        phase_d  = phase_q;
        step_d   = step_q;
        dur_d    = dur_q;
        wave_d   = wave_q;
        active_d = active_q;
        done_d   = '0;

        for (int v = 0; v < VOICES; v++) begin
            if (bus.load_new_note && (bus.load_voice == VIDX_W'(v))) begin
                step_d[v]   = bus.step_to_load;
                dur_d[v]    = bus.duration_to_load;
                wave_d[v]   = bus.wave_to_load;
                phase_d[v]  = '0;
                active_d[v] = (bus.duration_to_load != '0);
                done_d[v]   = (bus.duration_to_load == '0);
            end else begin
                if (beat_en && active_q[v]) begin
                    dur_d[v] = dur_q[v] - DUR_W'(1);
                    if (dur_q[v] == DUR_W'(1)) begin
                        active_d[v] = 1'b0;
                        done_d[v]   = 1'b1;
                    end
                end
                if (gen_en && active_q[v]) begin
                    phase_d[v] = phase_q[v] + PHASE_W'(step_q[v]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mixer. Evaluated on the post-update phase/wave/active so the registered
    // sample reflects this request's phase advance (1-cycle latency).
    // -------------------------------------------------------------------------
`ifdef NOTE_PLAYER_POLY_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    logic signed [ACC_W-1:0] mix_acc;
    logic signed [15:0]      mix_val;

    always_comb begin
        mix_acc = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (active_d[v]) begin
                mix_acc = mix_acc
                        + ACC_W'(voice_wave(phase_d[v][PHASE_W-1 -: 16], wave_d[v]));
            end
        end
        if (mix_acc > SAT_MAX) begin
            mix_val = 16'sh7FFF;
        end else if (mix_acc < SAT_MIN) begin
            mix_val = 16'sh8000;
        end else begin
            mix_val = mix_acc[15:0];
        end
    end
`else
    logic signed [15:0] mix_val;

    always_comb begin
        mix_val = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (active_d[v]) begin
                mix_val = mix_val
                        + (voice_wave(phase_d[v][PHASE_W-1 -: 16], wave_d[v]) >>> VIDX_W);
            end
        end
    end
`endif

    always_comb begin
        sample_d = sample_q;
        ready_d  = gen_en;
        if (gen_en) begin
            sample_d = mix_val;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= '0;
                step_q[v]  <= '0;
                dur_q[v]   <= '0;
                wave_q[v]  <= '0;
            end
            active_q <= '0;
            done_q   <= '0;
            sample_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                step_q[v]  <= step_d[v];
                dur_q[v]   <= dur_d[v];
                wave_q[v]  <= wave_d[v];
            end
            active_q <= active_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = ready_q;
    assign bus.done_with_note   = done_q;
    assign bus.voice_active     = active_q;

endmodule

// File: tb/tb_note_player_poly.sv
// -----------------------------------------------------------------------------
// tb_note_player_poly
//   Directed bench for note_player_poly (VIDX_W=2, PHASE_W=20, STEP_W=20,
//   DUR_W=6). Expected mixes follow NOTE_PLAYER_POLY_SAT_EN when defined.
// -----------------------------------------------------------------------------
module tb_note_player_poly;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    note_player_poly_if #(.VIDX_W(2), .STEP_W(20), .DUR_W(6)) bus ();

    note_player_poly #(
        .VIDX_W  (2),
        .PHASE_W (20),
        .STEP_W  (20),
        .DUR_W   (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 1000000");
        $fatal(1, "timeout");
    end

    // Mix of four full-scale voice values.
    function automatic int mix4(input int a, input int b, input int c, input int d);
        int s;
`ifdef NOTE_PLAYER_POLY_SAT_EN
        s = a + b + c + d;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`else
        s = (a >>> 2) + (b >>> 2) + (c >>> 2) + (d >>> 2);
`endif
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v, input int step, input int dur, input int wave);
        bus.load_new_note    = 1'b1;
        bus.load_voice       = 2'(v);
        bus.step_to_load     = 20'(step);
        bus.duration_to_load = 6'(dur);
        bus.wave_to_load     = 2'(wave);
        tick();
        bus.load_new_note    = 1'b0;
    endtask

    task automatic do_gen;
        bus.generate_next_sample = 1'b1;
        tick();
        bus.generate_next_sample = 1'b0;
    endtask

    task automatic do_beat;
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
    endtask

    task automatic test_reset;
        reset                    = 1'b1;
        bus.play_enable          = 1'b0;
        bus.load_new_note        = 1'b0;
        bus.load_voice           = '0;
        bus.step_to_load         = '0;
        bus.duration_to_load     = '0;
        bus.wave_to_load         = '0;
        bus.beat                 = 1'b0;
        bus.generate_next_sample = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.sample_out !== 16'sd0) begin failures++; $display("FAIL rst_sample: got %0d want 0", bus.sample_out); end
        checks++; if (bus.new_sample_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", bus.new_sample_ready); end
        checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL rst_active: got %b want 0000", bus.voice_active); end
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL rst_done: got %b want 0000", bus.done_with_note); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_square;
        int e;
        bus.play_enable = 1'b1;
        do_load(0, 'h10000, 3, 0);
        checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL sq_active: got %b want 0001", bus.voice_active); end
        do_gen();
        e = mix4(32767, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL sq_first: got %0d want %0d", bus.sample_out, e); end
        checks++; if (bus.new_sample_ready !== 1'b1) begin failures++; $display("FAIL sq_ready: got %b want 1", bus.new_sample_ready); end
        tick();
        checks++; if (bus.new_sample_ready !== 1'b0) begin failures++; $display("FAIL sq_ready_clr: got %b want 0", bus.new_sample_ready); end
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL sq_hold: got %0d want %0d", bus.sample_out, e); end
        repeat (6) do_gen();
        e = mix4(32767, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL sq_seventh: got %0d want %0d", bus.sample_out, e); end
        do_gen();
        e = mix4(-32768, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL sq_eighth: got %0d want %0d", bus.sample_out, e); end
        bus.play_enable = 1'b0;
        do_gen();
        checks++; if (bus.new_sample_ready !== 1'b0) begin failures++; $display("FAIL pause_ready: got %b want 0", bus.new_sample_ready); end
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL pause_hold: got %0d want %0d", bus.sample_out, e); end
        bus.play_enable = 1'b1;
        do_gen();
        e = mix4(-32768, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL pause_noadv: got %0d want %0d", bus.sample_out, e); end
    endtask

    task automatic test_waves;
        int e;
        do_load(0, 'h10000, 3, 1);
        do_gen();
        e = mix4(-28672, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL saw: got %0d want %0d", bus.sample_out, e); end
        do_load(0, 'h10000, 3, 2);
        do_gen();
        e = mix4(-24576, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL tri_rise: got %0d want %0d", bus.sample_out, e); end
        repeat (8) do_gen();
        e = mix4(24575, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL tri_fall: got %0d want %0d", bus.sample_out, e); end
        do_load(0, 'h10000, 3, 3);
        do_gen();
        checks++; if (bus.sample_out !== 16'sd0) begin failures++; $display("FAIL silent: got %0d want 0", bus.sample_out); end
        checks++; if (bus.new_sample_ready !== 1'b1) begin failures++; $display("FAIL silent_ready: got %b want 1", bus.new_sample_ready); end
    endtask

    task automatic test_duration;
        do_load(0, 'h10000, 3, 0);
        do_beat();
        bus.play_enable = 1'b0;
        do_beat();
        bus.play_enable = 1'b1;
        do_beat();
        checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL dur_mid_active: got %b want 0001", bus.voice_active); end
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL dur_mid_done: got %b want 0000", bus.done_with_note); end
        bus.play_enable = 1'b0;
        do_beat();
        bus.play_enable = 1'b1;
        checks++; if (bus.voice_active !== 4'b0001) begin failures++; $display("FAIL dur_paused_active: got %b want 0001", bus.voice_active); end
        do_beat();
        checks++; if (bus.done_with_note !== 4'b0001) begin failures++; $display("FAIL dur_done: got %b want 0001", bus.done_with_note); end
        checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL dur_end_active: got %b want 0000", bus.voice_active); end
        tick();
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL dur_done_clr: got %b want 0000", bus.done_with_note); end
    endtask

    task automatic test_mix;
        int e;
        do_load(0, 'h10000, 10, 0);
        do_load(1, 'h10000, 10, 0);
        do_gen();
        e = mix4(32767, 32767, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL mix_two: got %0d want %0d", bus.sample_out, e); end
        for (int v = 0; v < 4; v++) do_load(v, 'h80000, 10, 0);
        do_gen();
        e = mix4(-32768, -32768, -32768, -32768);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL mix_all_low: got %0d want %0d", bus.sample_out, e); end
        for (int v = 0; v < 4; v++) do_load(v, 'h10000, 10, 0);
        do_gen();
        e = mix4(32767, 32767, 32767, 32767);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL mix_all_high: got %0d want %0d", bus.sample_out, e); end
        for (int v = 0; v < 4; v++) do_load(v, 'h10000, 10, v);
        do_gen();
        e = mix4(32767, -28672, -24576, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL mix_waves: got %0d want %0d", bus.sample_out, e); end
        checks++; if (bus.voice_active !== 4'b1111) begin failures++; $display("FAIL mix_active: got %b want 1111", bus.voice_active); end
    endtask

    task automatic test_zero_dur;
        do_load(2, 0, 0, 0);
        checks++; if (bus.done_with_note !== 4'b0100) begin failures++; $display("FAIL zero_done: got %b want 0100", bus.done_with_note); end
        checks++; if (bus.voice_active !== 4'b1011) begin failures++; $display("FAIL zero_active: got %b want 1011", bus.voice_active); end
        tick();
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL zero_done_clr: got %b want 0000", bus.done_with_note); end
        do_load(3, 'h100, 5, 0);
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL restart_nodone: got %b want 0000", bus.done_with_note); end
        do_load(0, 0, 0, 0);
        do_load(1, 0, 0, 0);
        tick();
        bus.beat = 1'b1;
        do_load(3, 'h100, 5, 0);
        bus.beat = 1'b0;
        checks++; if (bus.voice_active !== 4'b1000) begin failures++; $display("FAIL ldbeat_active: got %b want 1000", bus.voice_active); end
        repeat (4) do_beat();
        checks++; if (bus.voice_active !== 4'b1000) begin failures++; $display("FAIL ldbeat_4_active: got %b want 1000", bus.voice_active); end
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL ldbeat_4_done: got %b want 0000", bus.done_with_note); end
        do_beat();
        checks++; if (bus.done_with_note !== 4'b1000) begin failures++; $display("FAIL ldbeat_5_done: got %b want 1000", bus.done_with_note); end
        checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL ldbeat_5_active: got %b want 0000", bus.voice_active); end
    endtask

    task automatic test_reset_mid;
        int e;
        do_load(0, 'h10000, 10, 0);
        do_gen();
        e = mix4(32767, 0, 0, 0);
        checks++; if (bus.sample_out !== 16'(e)) begin failures++; $display("FAIL pre_rst_sample: got %0d want %0d", bus.sample_out, e); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.sample_out !== 16'sd0) begin failures++; $display("FAIL mid_rst_sample: got %0d want 0", bus.sample_out); end
        checks++; if (bus.new_sample_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b want 0", bus.new_sample_ready); end
        checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL mid_rst_active: got %b want 0000", bus.voice_active); end
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL mid_rst_done: got %b want 0000", bus.done_with_note); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_gen();
        checks++; if (bus.sample_out !== 16'sd0) begin failures++; $display("FAIL post_rst_sample: got %0d want 0", bus.sample_out); end
        checks++; if (bus.new_sample_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", bus.new_sample_ready); end
        do_beat();
        checks++; if (bus.voice_active !== 4'b0000) begin failures++; $display("FAIL post_rst_active: got %b want 0000", bus.voice_active); end
        checks++; if (bus.done_with_note !== 4'b0000) begin failures++; $display("FAIL post_rst_done: got %b want 0000", bus.done_with_note); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_square();
        test_waves();
        test_duration();
        test_mix();
        test_zero_dur();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
